// File: rtl/hex_display_ctrl.sv
// Seven-segment controller for the HEX digit bank: accepts a hex value over valid/ready,
// decodes one digit per cycle into a shadow bank and commits the whole bank at once.
module hex_display_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_lz,
  input  logic [1:0]              mode,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    busy
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {7*NUM_DIGITS{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_e;
  typedef enum logic [1:0] {
    M_NORMAL = 2'b00,
    M_LAMP   = 2'b01,
    M_BLANK  = 2'b10,
    M_BLINK  = 2'b11
  } mode_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Shadow and display banks hold active-high patterns; polarity is applied at the output.
  state_e                  state_q;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    lz_q;
  logic [IDX_W-1:0]        idx_q;
  logic [6:0]              shadow_q  [NUM_DIGITS];
  logic [6:0]              display_q [NUM_DIGITS];
  logic [CNT_W-1:0]        blink_cnt_q;
  logic                    phase_q;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [3:0]              cur_nib;

  assign cur_nib     = value_q[4*idx_q +: 4];
  assign value_ready = reset_n && (state_q == S_IDLE);
  assign busy        = reset_n && (state_q != S_IDLE);
  assign seg_out     = seg_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      value_q <= '0;
      lz_q    <= 1'b0;
      idx_q   <= '0;
      // NOTE: the banks are cleared element by element because reset must show a blank display.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k]  <= '0;
        display_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (value_valid) begin
            value_q <= value_in;
            lz_q    <= blank_lz;
            idx_q   <= IDX_W'(NUM_DIGITS - 1);
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (lz_q && (cur_nib == 4'h0) && (idx_q != '0)) begin
            shadow_q[idx_q] <= '0;
          end else begin
            shadow_q[idx_q] <= hex7(cur_nib);
            lz_q            <= 1'b0;
          end
          if (idx_q == '0) state_q <= S_COMMIT;
          else             idx_q   <= idx_q - 1'b1;
        end
        S_COMMIT: begin
          for (int k = 0; k < NUM_DIGITS; k++) display_q[k] <= shadow_q[k];
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    logic [6:0] lit;
    // NOTE: defaults up front keep this block free of inferred latches.
    seg_d = '0;
    lit   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      unique case (mode_e'(mode))
        M_NORMAL: lit = display_q[k];
        M_LAMP:   lit = 7'h7F;
        M_BLANK:  lit = 7'h00;
        M_BLINK:  lit = phase_q ? 7'h00 : display_q[k];
      endcase
      seg_d[7*k +: 7] = SEG_ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) seg_q <= SEG_OFF;
    else          seg_q <= seg_d;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: table vectors, randomized loads against a
// digit-level reference model, and hand-written handshake / blink / reset sequences.
module tb_hex_display_ctrl;

  localparam int ND = 8;
  localparam int BD = 4;
  localparam logic [63:0] ALL_OFF = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4*ND-1:0] value_in;
  logic          value_valid;
  logic          value_ready;
  logic          blank_lz;
  logic [1:0]    mode;
  logic [7*ND-1:0] seg_out;
  logic          busy;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .blank_lz(blank_lz), .mode(mode), .seg_out(seg_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t_rst = 0;           // edges since the last edge seen with reset_n low
  logic [63:0] disp_exp;   // what mode 00 should show, one byte per digit

  always @(posedge clk) begin
    if (!reset_n) t_rst <= 0;
    else          t_rst <= t_rst + 1;
  end

  typedef struct {
    logic [31:0] value;
    logic        blz;
    logic [63:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [63:0] pack(input logic [7*ND-1:0] s);
    logic [63:0] r = '0;
    for (int k = 0; k < ND; k++) r[8*k +: 8] = {1'b0, s[7*k +: 7]};
    return r;
  endfunction

  // Reference: blank every digit above the most significant non-zero nibble.
  function automatic logic [63:0] model(input logic [31:0] v, input logic blz);
    logic [63:0] r = '0;
    int msd = 0;
    for (int k = 0; k < ND; k++) if (v[4*k +: 4] != 4'h0) msd = k;
    for (int k = 0; k < ND; k++) begin
      if (blz && k > msd) r[8*k +: 8] = 8'h7F;
      else                r[8*k +: 8] = {1'b0, ~PAT[v[4*k +: 4]]};
    end
    return r;
  endfunction

  // Expected seg_out for a mode applied before the edge just sampled; t is edges since reset.
  function automatic logic [63:0] view(input logic [1:0] m, input int t, input logic [63:0] disp);
    logic phase = (((t - 1) / BD) % 2) == 1;
    case (m)
      2'b00:   return disp;
      2'b01:   return 64'h0;
      2'b10:   return ALL_OFF;
      default: return phase ? ALL_OFF : disp;
    endcase
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!value_ready && w < 64) begin
      step();
      w++;
    end
    if (w >= 64) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: value_ready stayed %b for %0d cycles, required 1", value_ready, w);
    end
  endtask

  // Called on the sample after a transfer edge; returns on the first sample with ready high.
  task automatic count_busy(input logic [63:0] hold, output int n, output bit stable,
                            output bit busy_ok);
    n = 0;
    stable = 1'b1;
    busy_ok = 1'b1;
    while (!value_ready && n < 64) begin
      if (pack(seg_out) !== hold) stable = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      step();
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic blz, input logic [63:0] exp,
                         input string name);
    logic [63:0] hold;
    int n;
    bit stable, busy_ok;
    wait_ready();
    hold = pack(seg_out);
    value_in = v;
    blank_lz = blz;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    value_in = $urandom();
    blank_lz = ~blz;
    count_busy(hold, n, stable, busy_ok);
    check({name, " ready_low_cycles"}, 64'(n), 64'(ND + 1));
    check({name, " seg_stable_while_busy"}, 64'(stable), 64'd1);
    check({name, " busy_while_converting"}, 64'(busy_ok), 64'd1);
    check({name, " seg_before_commit_visible"}, pack(seg_out), hold);
    step();
    check({name, " seg_after_load"}, pack(seg_out), exp);
    disp_exp = exp;
  endtask

  initial begin
    int n;
    bit stable, busy_ok;
    logic [31:0] v;
    logic [1:0] m;
    logic blz;

    vecs[0] = '{32'h1234ABCD, 1'b0, 64'h7924_3019_0803_4621, "v_1234abcd"};
    vecs[1] = '{32'h00000000, 1'b1, 64'h7F7F_7F7F_7F7F_7F40, "v_zero_lz"};
    vecs[2] = '{32'h00F00000, 1'b1, 64'h7F7F_0E40_4040_4040, "v_00f00000_lz"};
    vecs[3] = '{32'h0000000A, 1'b1, 64'h7F7F_7F7F_7F7F_7F08, "v_a_lz"};
    vecs[4] = '{32'h00000000, 1'b0, 64'h4040_4040_4040_4040, "v_zero_nolz"};
    vecs[5] = '{32'h9EF00001, 1'b1, 64'h1006_0E40_4040_4079, "v_9ef00001_lz"};
    vecs[6] = '{32'h12345678, 1'b0, 64'h7924_3019_1202_7800, "v_12345678"};

    reset_n = 1'b0;
    value_in = '0;
    value_valid = 1'b0;
    blank_lz = 1'b0;
    mode = 2'b00;
    disp_exp = ALL_OFF;
    step();
    step();
    check("reset_seg_off", pack(seg_out), ALL_OFF);
    check("reset_ready_low", 64'(value_ready), 64'd0);
    check("reset_busy_low", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step();
    check("release_ready_high", 64'(value_ready), 64'd1);
    check("release_seg_off", pack(seg_out), ALL_OFF);

    for (int i = 0; i < 7; i++) do_load(vecs[i].value, vecs[i].blz, vecs[i].exp, vecs[i].name);

    // Display holds 12345678: lamp test, blank, back to normal.
    mode = 2'b01;
    step();
    check("mode_lamp", pack(seg_out), 64'h0);
    mode = 2'b10;
    step();
    check("mode_blank", pack(seg_out), ALL_OFF);
    mode = 2'b00;
    step();
    check("mode_normal_restored", pack(seg_out), disp_exp);

    mode = 2'b11;
    for (int i = 0; i < 6 * BD; i++) begin
      step();
      check("blink", pack(seg_out), view(2'b11, t_rst, disp_exp));
    end

    for (int i = 0; i < 20; i++) begin
      m = 2'($urandom_range(0, 3));
      mode = m;
      step();
      check("random_mode", pack(seg_out), view(m, t_rst, disp_exp));
    end
    mode = 2'b00;
    step();

    for (int i = 0; i < 12; i++) begin
      v = $urandom() >> (4 * $urandom_range(0, 8));
      blz = 1'($urandom_range(0, 1));
      do_load(v, blz, model(v, blz), "random_load");
    end

    // Valid held through busy with a second value: only accepted once ready returns.
    wait_ready();
    value_in = 32'hCAFE0123;
    blank_lz = 1'b0;
    value_valid = 1'b1;
    step();
    value_in = 32'h00000BAD;
    blank_lz = 1'b1;
    count_busy(disp_exp, n, stable, busy_ok);
    check("held_first_ready_low_cycles", 64'(n), 64'(ND + 1));
    step();
    check("held_first_value_shown", pack(seg_out), model(32'hCAFE0123, 1'b0));
    check("held_second_accepted", 64'(value_ready), 64'd0);
    value_valid = 1'b0;
    count_busy(model(32'hCAFE0123, 1'b0), n, stable, busy_ok);
    check("held_second_ready_low_cycles", 64'(n), 64'(ND + 1));
    step();
    check("held_second_value_shown", pack(seg_out), model(32'h00000BAD, 1'b1));
    disp_exp = model(32'h00000BAD, 1'b1);

    // Transfer and mode change on the same edge.
    wait_ready();
    value_in = 32'h0BEEF000;
    blank_lz = 1'b1;
    value_valid = 1'b1;
    mode = 2'b10;
    step();
    value_valid = 1'b0;
    check("simul_mode_blank", pack(seg_out), ALL_OFF);
    count_busy(ALL_OFF, n, stable, busy_ok);
    check("simul_ready_low_cycles", 64'(n), 64'(ND + 1));
    check("simul_seg_stable", 64'(stable), 64'd1);
    mode = 2'b00;
    step();
    check("simul_value_shown", pack(seg_out), model(32'h0BEEF000, 1'b1));

    // Reset during the third CONVERT cycle: nothing old or new survives.
    wait_ready();
    value_in = 32'h87654321;
    blank_lz = 1'b0;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    check("midreset_seg_off", pack(seg_out), ALL_OFF);
    check("midreset_ready_low", 64'(value_ready), 64'd0);
    check("midreset_busy_low", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step();
    check("midreset_idle_ready", 64'(value_ready), 64'd1);
    check("midreset_idle_busy", 64'(busy), 64'd0);
    repeat (ND + 4) step();
    check("midreset_no_late_commit", pack(seg_out), ALL_OFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
